// File: rtl/wb_writeback.sv
// Write-back stage of the five-stage pipeline: MEM/WB latch, result select,
// register-file write port, decode-stage bypass selects and retired-instruction count.
module wb_writeback #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                mem_valid,
   input  logic [1:0]          mem_wb,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic [DATA_W-1:0]   mem_alu,
   input  logic [REG_AW-1:0]   mem_writereg,
   input  logic [REG_AW-1:0]   id_rs,
   input  logic [REG_AW-1:0]   id_rt,
   output logic                RegWrite,
   output logic [REG_AW-1:0]   MEM_WB_Writereg,
   output logic [DATA_W-1:0]   MEM_WB_Writedata,
   output logic                fwd_a,
   output logic                fwd_b,
   output logic [RETIRE_W-1:0] retired
);

   logic                valid_q;
   logic [1:0]          wb_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   alu_q;
   logic [REG_AW-1:0]   reg_q;
   logic [RETIRE_W-1:0] retired_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         wb_q      <= 2'b00;
         rdata_q   <= '0;
         alu_q     <= '0;
         reg_q     <= '0;
         retired_q <= '0;
      end else begin
         // The held instruction leaves WB whenever the latch is not held,
         // including a flush that overrides a stall.
         if (valid_q && (!stall || flush))
            retired_q <= retired_q + RETIRE_W'(1);
         if (flush) begin
            valid_q <= 1'b0;
         end else if (!stall) begin
            valid_q <= mem_valid;
            wb_q    <= mem_wb;
            rdata_q <= mem_rdata;
            alu_q   <= mem_alu;
            reg_q   <= mem_writereg;
         end
      end
   end

   // $0 is hardwired to zero, so writes there (and bypasses from them) are dropped.
   assign RegWrite         = valid_q & wb_q[1] & (reg_q != '0);
   assign MEM_WB_Writereg  = reg_q;
   assign MEM_WB_Writedata = wb_q[0] ? rdata_q : alu_q;
   assign fwd_a            = RegWrite & (reg_q == id_rs);
   assign fwd_b            = RegWrite & (reg_q == id_rt);
   assign retired          = retired_q;

endmodule

// File: tb/tb_wb_writeback.sv
// Directed bench for wb_writeback with a behavioural model checked every cycle.
module tb_wb_writeback;

   localparam int DATA_W   = 32;
   localparam int REG_AW   = 5;
   localparam int RETIRE_W = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                stall = 1'b0;
   logic                flush = 1'b0;
   logic                mem_valid = 1'b0;
   logic [1:0]          mem_wb = 2'b00;
   logic [DATA_W-1:0]   mem_rdata = '0;
   logic [DATA_W-1:0]   mem_alu = '0;
   logic [REG_AW-1:0]   mem_writereg = '0;
   logic [REG_AW-1:0]   id_rs = '0;
   logic [REG_AW-1:0]   id_rt = '0;
   logic                RegWrite;
   logic [REG_AW-1:0]   MEM_WB_Writereg;
   logic [DATA_W-1:0]   MEM_WB_Writedata;
   logic                fwd_a;
   logic                fwd_b;
   logic [RETIRE_W-1:0] retired;

   int checks = 0;
   int errors = 0;

   wb_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW), .RETIRE_W(RETIRE_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_wb(mem_wb), .mem_rdata(mem_rdata),
      .mem_alu(mem_alu), .mem_writereg(mem_writereg),
      .id_rs(id_rs), .id_rt(id_rt),
      .RegWrite(RegWrite), .MEM_WB_Writereg(MEM_WB_Writereg),
      .MEM_WB_Writedata(MEM_WB_Writedata), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .retired(retired)
   );

   always #5 clk = ~clk;

   // Model: the instruction sitting in WB and the number that have left.
   bit          m_valid;
   bit          m_regwr;
   bit          m_load;
   int unsigned m_rdata;
   int unsigned m_alu;
   int unsigned m_dest;
   int unsigned m_count;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0; m_regwr = 0; m_load = 0;
         m_rdata = 0; m_alu = 0; m_dest = 0; m_count = 0;
      end else begin
         if (m_valid && (!stall || flush)) m_count = (m_count + 1) % (1 << RETIRE_W);
         if (flush) m_valid = 0;
         else if (!stall) begin
            m_valid = mem_valid;
            m_regwr = mem_wb[1];
            m_load  = mem_wb[0];
            m_rdata = mem_rdata;
            m_alu   = mem_alu;
            m_dest  = 32'(mem_writereg);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         bit          e_we;
         int unsigned e_data;
         e_we   = m_valid && m_regwr && (m_dest != 0);
         e_data = m_load ? m_rdata : m_alu;
         chk("model_regwrite", 32'(RegWrite), 32'(e_we));
         chk("model_writereg", 32'(MEM_WB_Writereg), m_dest);
         chk("model_writedata", MEM_WB_Writedata, e_data);
         chk("model_fwd_a", 32'(fwd_a), 32'(e_we && m_dest == 32'(id_rs)));
         chk("model_fwd_b", 32'(fwd_b), 32'(e_we && m_dest == 32'(id_rt)));
         chk("model_retired", 32'(retired), m_count);
      end
   end

   // Called at posedge+1: advances past the next rising edge, leaving time at posedge+1.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [1:0] wb, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [4:0] dst);
      mem_valid = v; mem_wb = wb; mem_rdata = rd; mem_alu = alu; mem_writereg = dst;
   endtask

   initial begin
      #12;
      chk("reset_regwrite", 32'(RegWrite), 0);
      chk("reset_writedata", MEM_WB_Writedata, 0);
      chk("reset_retired", 32'(retired), 0);
      rst = 1'b0;
      cycle();

      // Load with MemtoReg selects memory data.
      drive(1, 2'b11, 32'hDEADBEEF, 32'h10, 5'd8);
      cycle();
      chk("load_regwrite", 32'(RegWrite), 1);
      chk("load_writereg", 32'(MEM_WB_Writereg), 8);
      chk("load_writedata", MEM_WB_Writedata, 32'hDEADBEEF);
      chk("load_retired_before", 32'(retired), 0);
      drive(0, 2'b00, 0, 0, 5'd0);
      cycle();
      chk("load_retired_after", 32'(retired), 1);
      chk("load_gone_regwrite", 32'(RegWrite), 0);

      // ALU result to $0: no write, no bypass, still retires.
      drive(1, 2'b10, 0, 32'd5, 5'd0);
      cycle();
      chk("r0_regwrite", 32'(RegWrite), 0);
      chk("r0_fwd_a", 32'(fwd_a), 0);
      chk("r0_fwd_b", 32'(fwd_b), 0);
      chk("r0_writedata", MEM_WB_Writedata, 5);
      drive(0, 2'b00, 0, 0, 5'd0);
      cycle();
      chk("r0_retired", 32'(retired), 2);

      // Bypass on both operands, then rt moves away.
      id_rs = 5'd9; id_rt = 5'd9;
      drive(1, 2'b10, 32'hFFFF, 32'h1234, 5'd9);
      cycle();
      chk("byp_fwd_a", 32'(fwd_a), 1);
      chk("byp_fwd_b", 32'(fwd_b), 1);
      chk("byp_writedata", MEM_WB_Writedata, 32'h1234);
      id_rt = 5'd10;
      #1;
      chk("byp_fwd_a_keep", 32'(fwd_a), 1);
      chk("byp_fwd_b_drop", 32'(fwd_b), 0);

      // Capture write to $4, hold for three stalled cycles, then flush+stall.
      drive(1, 2'b10, 0, 32'h44, 5'd4);
      cycle();
      chk("stl_capture_reg", 32'(MEM_WB_Writereg), 4);
      chk("stl_capture_retired", 32'(retired), 3);
      drive(1, 2'b11, 32'h99, 32'h98, 5'd7);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stl_hold_regwrite", 32'(RegWrite), 1);
         chk("stl_hold_reg", 32'(MEM_WB_Writereg), 4);
         chk("stl_hold_data", MEM_WB_Writedata, 32'h44);
         chk("stl_hold_retired", 32'(retired), 3);
      end
      flush = 1'b1;
      cycle();
      chk("flush_regwrite", 32'(RegWrite), 0);
      chk("flush_retired", 32'(retired), 4);
      flush = 1'b0; stall = 1'b0;
      drive(0, 2'b00, 0, 0, 5'd0);
      cycle();
      chk("flush_retired_once", 32'(retired), 4);

      // Asynchronous reset mid-cycle discards the latched write at once.
      drive(1, 2'b10, 0, 32'h7, 5'd3);
      cycle();
      chk("prerst_regwrite", 32'(RegWrite), 1);
      drive(0, 2'b00, 0, 0, 5'd0);
      #3 rst = 1'b1;
      #1;
      chk("rst_regwrite", 32'(RegWrite), 0);
      chk("rst_writereg", 32'(MEM_WB_Writereg), 0);
      chk("rst_writedata", MEM_WB_Writedata, 0);
      chk("rst_fwd", 32'({fwd_a, fwd_b}), 0);
      chk("rst_retired", 32'(retired), 0);
      #2 rst = 1'b0;
      cycle();

      // Sixteen back-to-back instructions wrap the 4-bit counter.
      for (int i = 1; i <= 16; i++) begin
         drive(1, 2'b10, 0, 32'(i), 5'(i));
         cycle();
         chk("wrap_retired", 32'(retired), 32'((i - 1) % 16));
      end
      drive(0, 2'b00, 0, 0, 5'd0);
      cycle();
      chk("wrap_to_zero", 32'(retired), 0);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
